// File: rtl/xy_pkg.sv
// Shared types for the XY scan recovery block: coordinate widths and FSM states.
package xy_pkg;

    localparam int unsigned XW = 11;
    localparam int unsigned YW = 10;

    typedef logic [XW-1:0] x_t;
    typedef logic [YW-1:0] y_t;

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} xy_state_t;

endpackage

// File: rtl/xy_evt_detect.sv
// Registers the scan strobes and derives line-start (ls) and frame-start (fs) events.
module xy_evt_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic x_period,
    input  logic y_period,
    output logic ls,
    output logic fs
);

    logic xp_q;
    logic yp_q;
    logic yp_qq;
    logic ls_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xp_q      <= 1'b0;
            yp_q      <= 1'b0;
            yp_qq     <= 1'b0;
            ls_prev_q <= 1'b0;
        end else begin
            xp_q      <= x_period;
            yp_q      <= y_period;
            yp_qq     <= yp_q;
            ls_prev_q <= ls;
        end
    end

    assign ls = !xp_q;
    // A falling y strobe only marks a frame when the previous sample was a line start.
    assign fs = !yp_q && yp_qq && ls_prev_q;

endmodule

// File: rtl/xy_sync_recover.sv
// Rebuilds pixel coordinates from x/y scan strobes: measures line/frame size, locks, free-runs.
module xy_sync_recover
    import xy_pkg::*;
#(
    parameter int unsigned H_MAX      = 2048,
    parameter int unsigned V_MAX      = 1024,
    parameter int unsigned H_MIN      = 4,
    parameter int unsigned MISS_LIMIT = 2
) (
    input  logic          iCLK,
    input  logic          iRST_n,
    input  logic          iX_period,
    input  logic          iY_period,
    output logic [XW-1:0] oX_cnt,
    output logic [YW-1:0] oY_cnt,
    output logic          oLocked,
    output logic [XW-1:0] oH_len,
    output logic [YW-1:0] oV_len,
    output logic          oFrame_start,
    output logic          oErr
);

    localparam x_t         XLast   = x_t'(H_MAX - 1);
    localparam x_t         HMin    = x_t'(H_MIN);
    localparam y_t         YLast   = y_t'(V_MAX - 1);
    localparam logic [3:0] MissLim = 4'(MISS_LIMIT);

    logic ls;
    logic fs;

    xy_evt_detect u_evt (
        .clk      (iCLK),
        .rst_n    (iRST_n),
        .x_period (iX_period),
        .y_period (iY_period),
        .ls       (ls),
        .fs       (fs)
    );

    xy_state_t  state_q, state_d;
    x_t         x_q, x_d;
    y_t         y_q, y_d;
    x_t         h_meas_q, h_meas_d;
    logic       h_seen_q, h_seen_d;
    logic [3:0] miss_q, miss_d;
    x_t         h_len_q, h_len_d;
    y_t         v_len_q, v_len_d;
    logic       err_d;
    logic       exp_ls;
    logic       exp_fs;

    x_t   ox_q, ox_d;
    y_t   oy_q, oy_d;
    logic locked_q, locked_d;
    logic fstart_q, fstart_d;
    logic err_q;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        h_meas_d = h_meas_q;
        h_seen_d = h_seen_q;
        miss_d   = miss_q;
        h_len_d  = h_len_q;
        v_len_d  = v_len_q;
        err_d    = 1'b0;
        exp_ls   = 1'b0;
        exp_fs   = 1'b0;

        unique case (state_q)
            SEARCH: begin
                x_d      = '0;
                y_d      = '0;
                miss_d   = '0;
                h_seen_d = 1'b0;
                if (fs) begin
                    state_d = MEASURE;
                    x_d     = x_t'(1);
                end
            end

            MEASURE: begin
                x_d = x_q + 1'b1;
                if (ls) begin
                    x_d = '0;
                    y_d = y_q + 1'b1;
                    if (!h_seen_q) begin
                        h_meas_d = x_q + 1'b1;
                        h_seen_d = 1'b1;
                    end else if (x_q + 1'b1 != h_meas_q) begin
                        state_d = SEARCH;
                    end
                end
                // y_q already counts the line that the preceding LS opened, so it is the frame size.
                if (fs) begin
                    if (h_seen_q && h_meas_q >= HMin && y_q >= y_t'(2)) begin
                        state_d = LOCKED;
                        x_d     = x_t'(1);
                        y_d     = '0;
                        h_len_d = h_meas_q;
                        v_len_d = y_q;
                    end else begin
                        state_d = SEARCH;
                    end
                end
                if ((x_q == XLast && !ls) || y_q == YLast) begin
                    state_d = SEARCH;
                end
                if (state_d == SEARCH) begin
                    x_d = '0;
                    y_d = '0;
                end
            end

            LOCKED: begin
                if (x_q == h_len_q - 1'b1) begin
                    x_d = '0;
                    y_d = (y_q == v_len_q - 1'b1) ? '0 : y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
                exp_ls = (x_d == '0);
                exp_fs = (x_d == x_t'(1)) && (y_d == '0);
                // Any disagreement in a cycle counts once, even if both strobes are off.
                if (ls != exp_ls || fs != exp_fs) begin
                    err_d  = 1'b1;
                    miss_d = miss_q + 1'b1;
                end else if (ls) begin
                    miss_d = '0;
                end
                if (miss_d == MissLim) begin
                    state_d = SEARCH;
                    x_d     = '0;
                    y_d     = '0;
                    miss_d  = '0;
                end
            end

            default: begin
                state_d = SEARCH;
                x_d     = '0;
                y_d     = '0;
            end
        endcase

        locked_d = (state_d == LOCKED);
        ox_d     = locked_d ? x_d : '0;
        oy_d     = locked_d ? y_d : '0;
        fstart_d = locked_d && x_d == '0 && y_d == '0;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q  <= SEARCH;
            x_q      <= '0;
            y_q      <= '0;
            h_meas_q <= '0;
            h_seen_q <= 1'b0;
            miss_q   <= '0;
            h_len_q  <= '0;
            v_len_q  <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            locked_q <= 1'b0;
            fstart_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            h_meas_q <= h_meas_d;
            h_seen_q <= h_seen_d;
            miss_q   <= miss_d;
            h_len_q  <= h_len_d;
            v_len_q  <= v_len_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            locked_q <= locked_d;
            fstart_q <= fstart_d;
            err_q    <= err_d;
        end
    end

    assign oX_cnt       = ox_q;
    assign oY_cnt       = oy_q;
    assign oLocked      = locked_q;
    assign oH_len       = h_len_q;
    assign oV_len       = v_len_q;
    assign oFrame_start = fstart_q;
    assign oErr         = err_q;

endmodule

// File: tb/tb_xy_sync_recover.sv
// Directed bench: a scan-counter model drives the strobes; recovered outputs are checked against it.
module tb_xy_sync_recover;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        x_period = 1'b1;
    logic        y_period = 1'b1;
    logic [10:0] ox;
    logic [9:0]  oy;
    logic        locked;
    logic [10:0] hlen;
    logic [9:0]  vlen;
    logic        fstart;
    logic        err;

    always #5 clk = ~clk;

    xy_sync_recover dut (
        .iCLK         (clk),
        .iRST_n       (rst_n),
        .iX_period    (x_period),
        .iY_period    (y_period),
        .oX_cnt       (ox),
        .oY_cnt       (oy),
        .oLocked      (locked),
        .oH_len       (hlen),
        .oV_len       (vlen),
        .oFrame_start (fstart),
        .oErr         (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    int gen_h, gen_v, gen_x, gen_y;
    int prev_x, prev_y;
    bit hold_x = 1'b0;
    bit sup_arm = 1'b0;
    bit align_on = 1'b0;
    int align_bad, err_cnt, fs_cnt, unlock_cnt, locked_seen, ox_nonzero, last_fs, step_no;
    int n;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic clear_stats();
        align_bad   = 0;
        err_cnt     = 0;
        fs_cnt      = 0;
        unlock_cnt  = 0;
        locked_seen = 0;
        ox_nonzero  = 0;
        last_fs     = -1;
    endtask

    // Scan counter: x low for one sample at x=0; y low from (1,0) through (0,1).
    task automatic drive();
        x_period = !(gen_x == 0);
        if (hold_x) x_period = 1'b1;
        if (sup_arm && gen_x == 0 && gen_y == 5) begin
            x_period = 1'b1;
            sup_arm  = 1'b0;
        end
        y_period = !((gen_y == 0 && gen_x != 0) || (gen_y == 1 && gen_x == 0));
    endtask

    task automatic advance();
        if (gen_x >= gen_h - 1) begin
            gen_x = 0;
            gen_y = (gen_y >= gen_v - 1) ? 0 : gen_y + 1;
        end else begin
            gen_x = gen_x + 1;
        end
    endtask

    task automatic start_gen(input int h, input int v, input int x, input int y);
        gen_h  = h;
        gen_v  = v;
        gen_x  = x;
        gen_y  = y;
        prev_x = x;
        prev_y = y;
        drive();
    endtask

    // Outputs after an edge describe the sample driven two steps earlier (held in prev_*).
    task automatic step();
        @(posedge clk);
        #1;
        step_no++;
        if (err) err_cnt++;
        if (locked) locked_seen++;
        else unlock_cnt++;
        if (!locked && (ox != 0 || oy != 0)) ox_nonzero++;
        if (fstart) begin
            fs_cnt++;
            if (last_fs >= 0 && step_no - last_fs != gen_h * gen_v) align_bad++;
            last_fs = step_no;
        end
        if (align_on) begin
            if (!locked || int'(ox) != prev_x || int'(oy) != prev_y ||
                fstart != (prev_x == 0 && prev_y == 0)) align_bad++;
        end
        prev_x = gen_x;
        prev_y = gen_y;
        advance();
        drive();
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic wait_lock(input string tag, input int budget, output int cnt);
        cnt = 0;
        while (!locked && cnt < budget) begin
            step();
            cnt++;
        end
        check(tag, int'(locked), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        step_no = 0;
        clear_stats();
        start_gen(100, 40, 0, 39);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_x", int'(ox), 0);
        check("rst_y", int'(oy), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_hlen", int'(hlen), 0);
        check("rst_vlen", int'(vlen), 0);
        check("rst_fstart", int'(fstart), 0);
        check("rst_err", int'(err), 0);
        rst_n = 1'b1;

        // 100x40: lock after one measured frame, then track every sample
        wait_lock("a_lock", 4400, n);
        check("a_lock_time", int'(n >= 4000 && n <= 4200), 1);
        check("a_hlen", int'(hlen), 100);
        check("a_vlen", int'(vlen), 40);
        clear_stats();
        align_on = 1'b1;
        run(4000);
        align_on = 1'b0;
        check("a_align", align_bad, 0);
        check("a_err", err_cnt, 0);
        check("a_fstart", fs_cnt, 1);

        // One missing line start: a single miss, lock and alignment kept
        clear_stats();
        sup_arm  = 1'b1;
        align_on = 1'b1;
        run(4000);
        align_on = 1'b0;
        check("b_err", err_cnt, 1);
        check("b_align", align_bad, 0);
        check("b_unlock", unlock_cnt, 0);

        // Line length changes to 20: misses at x=20 and x=40 drop lock, then relock
        n = 0;
        while (!(gen_x == 0 && gen_y == 5) && n < 5000) begin
            step();
            n++;
        end
        gen_h = 20;
        clear_stats();
        run(60);
        check("c_err", err_cnt, 2);
        check("c_locked", int'(locked), 0);
        check("c_x_zero", int'(ox), 0);
        wait_lock("c_relock", 3000, n);
        check("c_hlen", int'(hlen), 20);
        check("c_vlen", int'(vlen), 40);

        // Asynchronous reset while locked, then relock within two frames
        run(300);
        check("e_pre_locked", int'(locked), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("e_rst_x", int'(ox), 0);
        check("e_rst_y", int'(oy), 0);
        check("e_rst_locked", int'(locked), 0);
        check("e_rst_hlen", int'(hlen), 0);
        check("e_rst_vlen", int'(vlen), 0);
        run(5);
        rst_n = 1'b1;
        wait_lock("e_relock", 1610, n);
        check("e_hlen", int'(hlen), 20);

        // 16x5: frame start every 80 samples, no errors
        rst_n = 1'b0;
        run(2);
        start_gen(16, 5, 0, 4);
        rst_n = 1'b1;
        wait_lock("d_lock", 300, n);
        check("d_hlen", int'(hlen), 16);
        check("d_vlen", int'(vlen), 5);
        clear_stats();
        align_on = 1'b1;
        run(320);
        align_on = 1'b0;
        check("d_align", align_bad, 0);
        check("d_err", err_cnt, 0);
        check("d_fstart", fs_cnt, 4);

        // Line starts vanish during measurement: measurement aborts, never locks
        rst_n = 1'b0;
        run(2);
        start_gen(100, 40, 0, 39);
        rst_n = 1'b1;
        n = 0;
        while (!(gen_x == 5 && gen_y == 0) && n < 300) begin
            step();
            n++;
        end
        hold_x = 1'b1;
        clear_stats();
        run(2200);
        check("f_never_locked", locked_seen, 0);
        check("f_x_zero", ox_nonzero, 0);
        hold_x = 1'b0;
        wait_lock("f_relock", 8300, n);
        check("f_hlen", int'(hlen), 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
